instruction_fetch_unit: RTL

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// Single-issue instruction fetch unit: pc register, combinational imem lookup,
// registered instr/instr_pc, IDLE/RUN/HALT control. Define HALT_ON_ZERO_EN to
// make a fetched all-zero word stop the unit until reset.
module instruction_fetch_unit (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic [15:0] r_fetch_count;
  logic        r_halted;
  logic [31:0] w_target;
  logic        w_zero_word;

  // Redirects always land on a word boundary.
  assign w_target    = branch_target & ~32'h0000_0003;
  assign w_zero_word = (imem_data == 32'h0000_0000);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= 32'h0000_0000;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_fetch_count <= 16'h0000;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state       <= S_RUN;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
        S_RUN: begin
          if (branch_taken) begin
            r_pc          <= w_target;
            r_instr_valid <= 1'b0;
          end else if (!stall) begin
`ifdef HALT_ON_ZERO_EN
            if (w_zero_word) begin
              r_state       <= S_HALT;
              r_instr_valid <= 1'b0;
              r_halted      <= 1'b1;
            end else begin
              r_instr       <= imem_data;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_pc          <= r_pc + 32'd4;
              if (r_fetch_count != 16'hFFFF)
                r_fetch_count <= r_fetch_count + 16'd1;
            end
`else
            r_instr       <= imem_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 32'd4;
            if (r_fetch_count != 16'hFFFF)
              r_fetch_count <= r_fetch_count + 16'd1;
`endif
          end
        end
        S_HALT: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign pc_plus8    = r_instr_pc + 32'd8;
  assign instr_valid = r_instr_valid;
  assign fetch_count = r_fetch_count;
  assign dbg_state   = r_state;
`ifdef HALT_ON_ZERO_EN
  assign halted      = r_halted;
`else
  // Zero words are ordinary instructions here, so the unit never halts.
  assign halted      = 1'b0;
  logic w_unused;
  assign w_unused    = r_halted ^ w_zero_word;
`endif

endmodule
